// File: rtl/sram_window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sram_window_fetch
// Purpose  : Walks a stride-1 3x3 window over an image in SRAM bank 0, issuing
//            one read per cycle and presenting each assembled window on a
//            valid/ready handshake in raster order.
// Revision : 1.0 - initial release
// ============================================================================
module sram_window_fetch #(
    parameter int IMG_WIDTH  = 52,
    parameter int IMG_HEIGHT = 52,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    CSn,
    output logic [3:0]              WEn,
    output logic [ADDR_WIDTH-1:0]   Addr,
    input  logic [DATA_WIDTH-1:0]   SramData,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic [5:0]              win_row,
    output logic [5:0]              win_col
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [3:0]                r_k;
    logic [5:0]                r_row;
    logic [5:0]                r_col;
    logic                      r_cap_en;
    logic [3:0]                r_cap_idx;
    logic                      r_done;
    logic [9*DATA_WIDTH-1:0]   r_win_data;
    logic [1:0]                w_dr;
    logic [1:0]                w_dc;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic                      w_last_col;
    logic                      w_last_row;
    logic                      w_fire;

    assign WEn      = 4'b1111;
    assign done     = r_done;
    assign win_data = r_win_data;
    assign win_row  = r_row;
    assign win_col  = r_col;

    assign w_last_col = ({26'd0, r_col} >= 32'(IMG_WIDTH - 3));
    assign w_last_row = ({26'd0, r_row} >= 32'(IMG_HEIGHT - 3));

    // Row-major split of the fetch index into window-relative (dr, dc).
    always_comb begin
        w_dr = 2'd0;
        w_dc = 2'd0;
        case (r_k)
            4'd1:    begin w_dr = 2'd0; w_dc = 2'd1; end
            4'd2:    begin w_dr = 2'd0; w_dc = 2'd2; end
            4'd3:    begin w_dr = 2'd1; w_dc = 2'd0; end
            4'd4:    begin w_dr = 2'd1; w_dc = 2'd1; end
            4'd5:    begin w_dr = 2'd1; w_dc = 2'd2; end
            4'd6:    begin w_dr = 2'd2; w_dc = 2'd0; end
            4'd7:    begin w_dr = 2'd2; w_dc = 2'd1; end
            4'd8:    begin w_dr = 2'd2; w_dc = 2'd2; end
            default: begin w_dr = 2'd0; w_dc = 2'd0; end
        endcase
    end

    assign w_addr = ADDR_WIDTH'(32'(BASE_ADDR)
                    + ({26'd0, r_row} + {30'd0, w_dr}) * 32'(IMG_WIDTH)
                    + {26'd0, r_col} + {30'd0, w_dc});

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        CSn       = 1'b1;
        Addr      = '0;
        win_valid = 1'b0;
        w_fire    = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                CSn  = 1'b0;
                Addr = w_addr;
                if (r_k == 4'd8) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                w_next = OUT;
            end
            OUT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    w_fire = 1'b1;
                    w_next = (w_last_col && w_last_row) ? IDLE : FETCH;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so the capture slot is the
    // fetch index registered on the previous cycle.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_k        <= 4'd0;
            r_row      <= 6'd0;
            r_col      <= 6'd0;
            r_cap_en   <= 1'b0;
            r_cap_idx  <= 4'd0;
            r_done     <= 1'b0;
            r_win_data <= '0;
        end else begin
            r_cap_en  <= (r_state == FETCH);
            r_cap_idx <= r_k;
            r_done    <= w_fire && w_last_col && w_last_row;
            if (r_cap_en) begin
                r_win_data[r_cap_idx*DATA_WIDTH +: DATA_WIDTH] <= SramData;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row <= 6'd0;
                        r_col <= 6'd0;
                        r_k   <= 4'd0;
                    end
                end
                FETCH: begin
                    r_k <= r_k + 4'd1;
                end
                OUT: begin
                    if (w_fire) begin
                        r_k <= 4'd0;
                        if (!w_last_col) begin
                            r_col <= r_col + 6'd1;
                        end else if (!w_last_row) begin
                            r_col <= 6'd0;
                            r_row <= r_row + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
